// File: rtl/hs32_pkg.sv
// Shared hs32 definitions: datapath width, register count and register index type.
package hs32_pkg;
  localparam int DW   = 32;
  localparam int NREG = 16;

  typedef logic [3:0] reg_idx_t;
endpackage

// File: rtl/hs32_regfile_if.sv
// Request/response bus between a register-file client (master) and hs32_regfile (slave).
interface hs32_regfile_if #(parameter int DW = hs32_pkg::DW) ();
  import hs32_pkg::*;

  logic          enable_n;
  logic          req_valid;
  logic          req_ready;
  logic          rw;
  reg_idx_t      rsrc;
  reg_idx_t      rm;
  reg_idx_t      rdst;
  logic [DW-1:0] din;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] dout;
  logic [DW-1:0] dout_b;

  modport master (
    output enable_n, req_valid, rw, rsrc, rm, rdst, din, rsp_ready,
    input  req_ready, rsp_valid, dout, dout_b
  );

  modport slave (
    input  enable_n, req_valid, rw, rsrc, rm, rdst, din, rsp_ready,
    output req_ready, rsp_valid, dout, dout_b
  );
endinterface

// File: rtl/hs32_regfile_mem.sv
// Register storage: one synchronous write port, two combinational read ports, async clear.
module hs32_regfile_mem
  #(parameter int DW   = hs32_pkg::DW,
    parameter int NREG = hs32_pkg::NREG)
  (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  hs32_pkg::reg_idx_t  waddr,
  input  logic [DW-1:0]       wdata,
  input  hs32_pkg::reg_idx_t  raddr_a,
  input  hs32_pkg::reg_idx_t  raddr_b,
  output logic [DW-1:0]       rdata_a,
  output logic [DW-1:0]       rdata_b
  );

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
endmodule

// File: rtl/hs32_regfile.sv
// hs32 register file: valid/ready request handshake, write-first forwarding and a
// one-entry response register in front of the storage array.
module hs32_regfile
  #(parameter int DW   = hs32_pkg::DW,
    parameter int NREG = hs32_pkg::NREG)
  (
  input  logic          clk,
  input  logic          reset,
  hs32_regfile_if.slave bus
  );
  import hs32_pkg::*;

  logic          accept;
  logic          wr_en;
  logic [DW-1:0] mem_a;
  logic [DW-1:0] mem_b;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;

  // reset is folded in so nothing is offered while the array is being cleared
  assign bus.req_ready = !reset && !bus.enable_n && (!bus.rsp_valid || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign wr_en         = accept && bus.rw;

  hs32_regfile_mem #(.DW(DW), .NREG(NREG)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_en),
    .waddr   (bus.rdst),
    .wdata   (bus.din),
    .raddr_a (bus.rsrc),
    .raddr_b (bus.rm),
    .rdata_a (mem_a),
    .rdata_b (mem_b)
  );

  // write-first: a read of the register being written returns the new data
  assign rd_a = (bus.rw && (bus.rsrc == bus.rdst)) ? bus.din : mem_a;
  assign rd_b = (bus.rw && (bus.rm   == bus.rdst)) ? bus.din : mem_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.dout      <= '0;
      bus.dout_b    <= '0;
    end else if (accept) begin
      bus.rsp_valid <= 1'b1;
      bus.dout      <= rd_a;
      bus.dout_b    <= rd_b;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hs32_regfile.sv
// Self-checking bench for hs32_regfile: directed scenarios plus random traffic
// compared against an array-based reference model of the register file.
module tb_hs32_regfile;
  logic clk;
  logic reset;

  hs32_regfile_if #(.DW(32)) bus ();

  hs32_regfile #(.DW(32), .NREG(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  logic [31:0] m_regs [16];
  logic        m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_valid = 1'b0;
    m_a     = '0;
    m_b     = '0;
  endtask

  // One clock cycle: drive at negedge, check ready, then check the response after the edge.
  task automatic cyc(input logic v, input logic w, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] d, input logic [31:0] data, input logic en_n,
                     input logic rr);
    logic exp_ready;
    logic acc;
    @(negedge clk);
    bus.req_valid = v;
    bus.rw        = w;
    bus.rsrc      = a;
    bus.rm        = b;
    bus.rdst      = d;
    bus.din       = data;
    bus.enable_n  = en_n;
    bus.rsp_ready = rr;
    #1;
    exp_ready = !en_n && (!m_valid || rr);
    chk("req_ready", {31'b0, bus.req_ready}, {31'b0, exp_ready});
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      if (w) m_regs[d] = data;
      m_a     = m_regs[a];
      m_b     = m_regs[b];
      m_valid = 1'b1;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("dout", bus.dout, m_a);
      chk("dout_b", bus.dout_b, m_b);
    end
  endtask

  // Reset raised mid-cycle while a write is presented; it must clear at once and drop the write.
  task automatic mid_reset(input logic [3:0] d, input logic [31:0] data);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.rw        = 1'b1;
    bus.rdst      = d;
    bus.rsrc      = d;
    bus.rm        = d;
    bus.din       = data;
    bus.enable_n  = 1'b0;
    bus.rsp_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_dout", bus.dout, 32'd0);
    chk("rst_dout_b", bus.dout_b, 32'd0);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_rsp_valid_edge", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_req_ready_edge", {31'b0, bus.req_ready}, 32'd0);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_clear();
    reset         = 1'b1;
    bus.enable_n  = 1'b0;
    bus.req_valid = 1'b0;
    bus.rw        = 1'b0;
    bus.rsrc      = '0;
    bus.rm        = '0;
    bus.rdst      = '0;
    bus.din       = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("init_dout", bus.dout, 32'd0);
    chk("init_req_ready", {31'b0, bus.req_ready}, 32'd0);
    #1;
    reset = 1'b0;

    // write then read
    cyc(1, 1, 4'd0, 4'd0, 4'd5, 32'hDEADBEEF, 0, 1);
    cyc(1, 0, 4'd5, 4'd5, 4'd0, 32'h0, 0, 1);
    chk("wr_rd_a", bus.dout, 32'hDEADBEEF);
    chk("wr_rd_b", bus.dout_b, 32'hDEADBEEF);

    // write-first forwarding
    cyc(1, 1, 4'd0, 4'd0, 4'd4, 32'h0000000A, 0, 1);
    cyc(1, 1, 4'd3, 4'd4, 4'd3, 32'h12345678, 0, 1);
    chk("fwd_a", bus.dout, 32'h12345678);
    chk("fwd_b", bus.dout_b, 32'h0000000A);

    // mid-stream reset, then every register reads back zero
    cyc(1, 1, 4'd9, 4'd9, 4'd9, 32'hCAFEF00D, 0, 0);
    mid_reset(4'd9, 32'h55AA55AA);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 4'(i), 4'(15 - i), 4'd0, 32'h0, 0, 1);
      chk("post_rst_a", bus.dout, 32'd0);
      chk("post_rst_b", bus.dout_b, 32'd0);
    end

    // fill with distinct values, then 16 back-to-back reads
    for (int i = 0; i < 16; i++) cyc(1, 1, 4'(i), 4'(i), 4'(i), 32'h1000 + i, 0, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 4'(i), 4'(15 - i), 4'd0, 32'h0, 0, 1);
      chk("stream_a", bus.dout, 32'h1000 + i);
    end

    // backpressure: second request waits for rsp_ready
    cyc(1, 0, 4'd5, 4'd6, 4'd0, 32'h0, 0, 1);
    repeat (3) begin
      cyc(1, 1, 4'd2, 4'd2, 4'd2, 32'hBAD0BAD0, 0, 0);
      chk("bp_hold_a", bus.dout, 32'h1005);
    end
    cyc(1, 1, 4'd2, 4'd2, 4'd2, 32'hBAD0BAD0, 0, 1);
    chk("bp_release", bus.dout, 32'hBAD0BAD0);

    // enable_n gating: write to r7 blocked, pending response still drains
    cyc(1, 0, 4'd1, 4'd1, 4'd0, 32'h0, 0, 0);
    cyc(1, 1, 4'd7, 4'd7, 4'd7, 32'hFFFFFFFF, 1, 0);
    cyc(1, 1, 4'd7, 4'd7, 4'd7, 32'hFFFFFFFF, 1, 1);
    chk("en_drained", {31'b0, bus.rsp_valid}, 32'd0);
    cyc(1, 0, 4'd7, 4'd7, 4'd0, 32'h0, 0, 1);
    chk("en_r7", bus.dout, 32'h1007);

    // random traffic with occasional resets
    for (int k = 0; k < 500; k++) begin
      if (k % 167 == 100) begin
        mid_reset(4'($urandom_range(0, 15)), $urandom);
      end else begin
        cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hs32_regfile.md
HS32_REGFILE -- requirements
Module: hs32_regfile

Interface
REQ-001 SHALL have parameter: DW, 32, data width in bits.
REQ-002 SHALL have parameter: NREG, 16, number of general registers (4-bit index).
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: enable_n  in  1  active-low enable; when high, no request is accepted.
REQ-006 SHALL have port: req_valid  in  1  request present.
REQ-007 SHALL have port: req_ready  out  1  request can be accepted this cycle.
REQ-008 SHALL have port: rw  in  1  1 = write din to rdst and read both ports; 0 = read only.
REQ-009 SHALL have port: rsrc  in  4  read-port A register index.
REQ-010 SHALL have port: rm  in  4  read-port B register index.
REQ-011 SHALL have port: rdst  in  4  write register index.
REQ-012 SHALL have port: din  in  DW  write data.
REQ-013 SHALL have port: rsp_valid  out  1  response holding read data.
REQ-014 SHALL have port: rsp_ready  in  1  consumer accepts the response.
REQ-015 SHALL have port: dout  out  DW  port-A read data.
REQ-016 SHALL have port: dout_b  out  DW  port-B read data.

Function
REQ-017 SHALL accept a request on a rising edge where req_valid, req_ready and !enable_n are all high.
REQ-018 SHALL drive req_ready = !enable_n && (!rsp_valid || rsp_ready), so the one-entry response register is the only buffering.
REQ-019 SHALL, on an accepted write, store din into register rdst at the accept edge.
REQ-020 SHALL return read data one cycle after acceptance: rsp_valid rises on the accept edge, with dout = reg[rsrc] and dout_b = reg[rm].
REQ-021 SHALL be write-first: when rw=1 and rsrc==rdst (or rm==rdst), the returned data equals din.
REQ-022 SHALL hold dout, dout_b and rsp_valid stable while rsp_valid && !rsp_ready.
REQ-023 SHALL clear rsp_valid on an edge where rsp_ready is high and no new request is accepted.
REQ-024 SHALL, on an edge with simultaneous rsp_ready and a new acceptance, replace the response with the new one and keep rsp_valid high, giving one request per cycle of throughput.
REQ-025 SHALL ignore req_valid, rw and din when the request is not accepted: no register is modified and the response is unchanged.
REQ-026 SHALL still drain the pending response via rsp_ready when enable_n goes high; only acceptance is blocked.
REQ-027 SHALL treat all NREG registers as general purpose, with no hardwired-zero register.
REQ-028 SHALL make a write visible to any request accepted on a later cycle, with no extra hazard latency.

Reset
REQ-029 SHALL, while reset is high, immediately clear all registers to 0, rsp_valid to 0, and dout and dout_b to 0, independent of clk.
REQ-030 SHALL discard any pending response and any in-flight write when reset is asserted mid-operation; no write from the reset cycle survives.
REQ-031 SHALL drive req_ready low while reset is high and accept the first request on the first rising edge after reset deasserts.

Structure
REQ-032 SHALL take DW, NREG and the 4-bit register-index type from the shared package hs32_pkg, which is shared with hs32_alu.
REQ-033 SHALL place storage in one sub-module, hs32_regfile_mem, providing 1 write port and 2 combinational read ports with asynchronous clear.
REQ-034 SHALL keep the handshake, forwarding mux and response register in hs32_regfile.

Verification
REQ-035 SHALL cover reset: assert reset mid-stream, then read r0..r15 -> all responses 0 and rsp_valid was 0 during reset.
REQ-036 SHALL cover write then read: write r5=0xDEADBEEF, next cycle read rsrc=5, rm=5 -> dout = dout_b = 0xDEADBEEF one cycle after acceptance.
REQ-037 SHALL cover write-first forwarding: rw=1, rdst=3, rsrc=3, rm=4, din=0x12345678, r4=0x0A -> dout=0x12345678, dout_b=0x0A.
REQ-038 SHALL cover backpressure: hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, the response is unchanged, and the second request is not accepted until rsp_ready=1.
REQ-039 SHALL cover back-to-back streaming: with rsp_ready=1, issue 16 consecutive reads -> 16 responses on 16 consecutive cycles, in order.
REQ-040 SHALL cover enable_n gating: enable_n=1 with req_valid=1, rw=1, rdst=7 -> no acceptance, r7 unchanged, and the pending response still drains.
